// File: rtl/pc_msg_deframer.sv
// pc_msg_deframer: assembles 3-word PC messages from a FWFT FIFO into validated START/STOP commands
module pc_msg_deframer #(
  parameter int XB_SIZE = 32,
  parameter int MAX_LEN = 4096,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               pc_msg_valid,
  input  logic [XB_SIZE-1:0] pc_msg,
  output logic               pc_msg_ack,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_start,
  output logic               cmd_stop,
  output logic [XB_SIZE-1:0] cmd_len,
  output logic [XB_SIZE-1:0] cmd_addr,
  output logic [XB_SIZE-1:0] cmd_coeff,
  output logic               msg_error,
  output logic [7:0]         err_count
);
  typedef enum logic [1:0] {W0, W1, W2, HOLD} state_t;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [XB_SIZE-1:0] w0, w1;
  logic is_stop, is_start, in_msg, timed_out, bad_msg, drop;
  assign pc_msg_ack = pc_msg_valid && !RESET && state != HOLD;
  assign is_stop    = w0 == '0 && w1 == '0 && pc_msg == '0;
  assign is_start   = w0 != '0 && w0 <= XB_SIZE'(MAX_LEN) && pc_msg != '0;
  assign in_msg     = state == W1 || state == W2;
  // a word arriving on the limit cycle takes priority over the timeout
  assign timed_out  = in_msg && !pc_msg_ack && cnt == LIM;
  assign bad_msg    = state == W2 && pc_msg_ack && !is_stop && !is_start;
  assign drop       = timed_out || bad_msg;
  // message assembly, command hold, inter-word timeout and error accounting
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= W0;
      cnt       <= '0;
      w0        <= '0;
      w1        <= '0;
      cmd_valid <= 1'b0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_len   <= '0;
      cmd_addr  <= '0;
      cmd_coeff <= '0;
      msg_error <= 1'b0;
      err_count <= '0;
    end else begin
      msg_error <= drop;
      if (drop) err_count <= err_count + 8'(err_count != 8'hff);
      cnt <= (!in_msg || pc_msg_ack || drop) ? '0 : cnt + 1'b1;
      case (state)
        W0: if (pc_msg_ack) begin
          w0    <= pc_msg;
          state <= W1;
        end
        W1: if (pc_msg_ack) begin
          w1    <= pc_msg;
          state <= W2;
        end else if (drop) state <= W0;
        W2: if (pc_msg_ack && !drop) begin
          state     <= HOLD;
          cmd_valid <= 1'b1;
          cmd_start <= is_start;
          cmd_stop  <= is_stop;
          cmd_len   <= w0;
          cmd_addr  <= w1;
          cmd_coeff <= pc_msg;
        end else if (drop) state <= W0;
        HOLD: if (cmd_ready) begin
          state     <= W0;
          cmd_valid <= 1'b0;
          cmd_start <= 1'b0;
          cmd_stop  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_msg_deframer.sv
// tb_pc_msg_deframer: FIFO model, command scoreboard, vector table and timing corner cases
module tb_pc_msg_deframer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic pc_msg_valid = 1'b0;
  logic [31:0] pc_msg = '0;
  logic pc_msg_ack, cmd_valid, cmd_ready, cmd_start, cmd_stop, msg_error;
  logic [31:0] cmd_len, cmd_addr, cmd_coeff;
  logic [7:0] err_count;
  pc_msg_deframer #(.XB_SIZE(32), .MAX_LEN(4096), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .pc_msg_valid(pc_msg_valid), .pc_msg(pc_msg),
    .pc_msg_ack(pc_msg_ack), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
    .cmd_coeff(cmd_coeff), .msg_error(msg_error), .err_count(err_count)
  );
  always #5 CLK = ~CLK;
  typedef struct { logic start; logic stop; logic [31:0] len, addr, coeff; } cmd_t;
  typedef struct { logic [31:0] w0, w1, w2; logic err; logic start; } vec_t;
  logic [31:0] fifo[$];
  cmd_t exp_q[$];
  vec_t vecs[8];
  int total = 0, passed = 0, exp_err = 0, seen_err = 0;
  logic s_ack, s_valid, s_stop, s_error, prev_valid = 1'b0;
  logic [7:0] s_errc;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask
  task automatic drive();
    pc_msg_valid = fifo.size() != 0;
    pc_msg = pc_msg_valid ? fifo[0] : '0;
  endtask
  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    drive();
  endtask
  // one clock: sample mid-cycle, score rising commands, then pop acked word after the edge
  task automatic cyc();
    cmd_t e;
    @(negedge CLK);
    s_ack = pc_msg_ack;
    s_valid = cmd_valid;
    s_stop = cmd_stop;
    s_error = msg_error;
    s_errc = err_count;
    if (msg_error) seen_err++;
    check("onehot", 32'(cmd_start) + 32'(cmd_stop), cmd_valid ? 32'd1 : 32'd0);
    if (cmd_valid && !prev_valid) begin
      check("err_with_cmd", 32'(msg_error), 0);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_cmd: got cmd len %0h expected none", cmd_len);
      end else begin
        e = exp_q.pop_front();
        check("cmd_start", 32'(cmd_start), 32'(e.start));
        check("cmd_stop", 32'(cmd_stop), 32'(e.stop));
        check("cmd_len", cmd_len, e.len);
        check("cmd_addr", cmd_addr, e.addr);
        check("cmd_coeff", cmd_coeff, e.coeff);
      end
    end
    prev_valid = cmd_valid;
    @(posedge CLK);
    #1;
    if (s_ack) fifo.delete(0);
    drive();
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    fifo.delete();
    drive();
    exp_q.delete();
    repeat (2) cyc();
    RESET = 1'b0;
    exp_err = 0;
    seen_err = 0;
    check("rst_valid", 32'(s_valid), 0);
    check("rst_error", 32'(s_error), 0);
    check("rst_errcnt", 32'(s_errc), 0);
  endtask
  task automatic run_msg(input logic [31:0] a, b, c, input logic err, input logic start);
    cmd_ready = 1'b1;
    push(a);
    push(b);
    push(c);
    if (err) exp_err++;
    else exp_q.push_back('{start, !start, a, b, c});
    repeat (6) cyc();
    check("err_count", 32'(s_errc), exp_err > 255 ? 32'd255 : 32'(exp_err));
    check("err_pulses", seen_err, exp_err);
    check("cmd_drained", exp_q.size(), 0);
  endtask
  initial begin
    vecs[0] = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{32'h140, 32'h0012_0000, 32'h3c23_d70a, 1'b0, 1'b1};
    vecs[2] = '{32'h0, 32'h5, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{32'd4097, 32'h1, 32'h3f80_0000, 1'b1, 1'b0};
    vecs[5] = '{32'd4096, 32'hffff_ffff, 32'h3f80_0000, 1'b0, 1'b1};
    vecs[6] = '{32'h1, 32'h2, 32'h0, 1'b1, 1'b0};
    vecs[7] = '{32'h0, 32'h0, 32'h1, 1'b1, 1'b0};
    cmd_ready = 1'b0;
    do_reset();
    // STOP latency: three consecutive acks, command on the following cycle
    exp_q.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 32'h0});
    push(0); push(0); push(0);
    repeat (3) begin cyc(); check("stop_ack", 32'(s_ack), 1); end
    cyc();
    check("stop_valid", 32'(s_valid), 1);
    check("stop_flag", 32'(s_stop), 1);
    check("hold_ack", 32'(s_ack), 0);
    cmd_ready = 1'b1;
    cyc();
    check("handshake_valid", 32'(s_valid), 1);
    cyc();
    check("retired_valid", 32'(s_valid), 0);
    // vector table
    for (int i = 0; i < 8; i++) run_msg(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].err, vecs[i].start);
    // backpressure: STOP words stay queued while START is held
    do_reset();
    cmd_ready = 1'b0;
    push(32'h140); push(32'h0012_0000); push(32'h3c23_d70a);
    push(0); push(0); push(0);
    exp_q.push_back('{1'b1, 1'b0, 32'h140, 32'h0012_0000, 32'h3c23_d70a});
    exp_q.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 32'h0});
    repeat (3) cyc();
    repeat (20) begin cyc(); check("bp_ack", 32'(s_ack), 0); end
    check("bp_fifo_left", fifo.size(), 3);
    cmd_ready = 1'b1;
    repeat (10) cyc();
    check("bp_drained", exp_q.size(), 0);
    check("bp_fifo_empty", fifo.size(), 0);
    check("bp_no_err", seen_err, 0);
    // timeout: sixteen idle cycles after a lone word
    do_reset();
    push(32'h140);
    cyc();
    check("to_ack", 32'(s_ack), 1);
    repeat (16) cyc();
    check("to_quiet", seen_err, 0);
    cyc();
    check("to_pulse", 32'(s_error), 1);
    check("to_errcnt", 32'(s_errc), 1);
    exp_err = 1;
    // words arriving on the limit cycle win over the timeout
    exp_q.push_back('{1'b1, 1'b0, 32'h140, 32'h0012_0000, 32'h3c23_d70a});
    push(32'h140);
    cyc();
    repeat (15) cyc();
    push(32'h0012_0000);
    cyc();
    check("limit_ack1", 32'(s_ack), 1);
    repeat (15) cyc();
    push(32'h3c23_d70a);
    cyc();
    check("limit_ack2", 32'(s_ack), 1);
    repeat (3) cyc();
    check("limit_drained", exp_q.size(), 0);
    check("limit_errs", seen_err, 1);
    check("limit_errcnt", 32'(s_errc), 1);
    // reset mid-message discards the partial, then decoding resumes cleanly
    cmd_ready = 1'b1;
    push(32'h140); push(32'h0012_0000); push(32'h3c23_d70a);
    repeat (2) cyc();
    do_reset();
    repeat (4) cyc();
    check("rst_no_cmd", 32'(s_valid), 0);
    run_msg(32'h20, 32'h0000_1000, 32'h3c23_d70a, 1'b0, 1'b1);
    // saturation
    for (int i = 0; i < 300; i++) begin
      push(0); push(5); push(0);
      exp_err++;
      repeat (4) cyc();
    end
    cyc();
    check("sat_errcnt", 32'(s_errc), 255);
    check("sat_pulses", seen_err, 300);
    run_msg(0, 0, 0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
